// File: rtl/floating_point_tlast_tuser_pkg.sv
// Shared types and default sizes for the tlast/tuser sideband ROM sequencer.
package floating_point_tlast_tuser_pkg;

   localparam int unsigned DEF_ADDR_W = 4;
   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_DEPTH  = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } seq_state_e;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] tuser;
      logic                  tlast;
   } beat_t;

endpackage

// File: rtl/floating_point_tlast_tuser_skid2.sv
// Two-entry beat buffer: registered AXIS output stage plus one skid entry.
module floating_point_tlast_tuser_skid2 #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_tuser,
   input  logic              push_tlast,
   input  logic              m_axis_tready,
   output logic              m_axis_tvalid,
   output logic [DATA_W-1:0] m_axis_tuser,
   output logic              m_axis_tlast,
   output logic [1:0]        occ_c
);

   logic              skid_valid;
   logic [DATA_W-1:0] skid_tuser;
   logic              skid_tlast;
   logic              pop_c;

   assign pop_c = m_axis_tvalid & m_axis_tready;
   assign occ_c = 2'(m_axis_tvalid) + 2'(skid_valid);

   // The skid entry is always older than an incoming push, so it refills the output first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tuser  <= '0;
         m_axis_tlast  <= 1'b0;
         skid_valid    <= 1'b0;
         skid_tuser    <= '0;
         skid_tlast    <= 1'b0;
      end else if (pop_c) begin
         if (skid_valid) begin
            m_axis_tuser <= skid_tuser;
            m_axis_tlast <= skid_tlast;
            if (push) begin
               skid_tuser <= push_tuser;
               skid_tlast <= push_tlast;
            end else begin
               skid_valid <= 1'b0;
            end
         end else if (push) begin
            m_axis_tuser <= push_tuser;
            m_axis_tlast <= push_tlast;
         end else begin
            m_axis_tvalid <= 1'b0;
         end
      end else if (push) begin
         if (!m_axis_tvalid) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tuser  <= push_tuser;
            m_axis_tlast  <= push_tlast;
         end else begin
            skid_valid <= 1'b1;
            skid_tuser <= push_tuser;
            skid_tlast <= push_tlast;
         end
      end
   end

endmodule

// File: rtl/floating_point_tlast_tuser_seq.sv
// Sweeps the sideband ROM and streams each byte as an AXIS beat (tuser), tlast on the final entry.
// FLOATING_POINT_TLAST_TUSER_SEQ_LOOP_EN: wrap the address and stream endlessly.
module floating_point_tlast_tuser_seq
   import floating_point_tlast_tuser_pkg::*;
#(
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rom_dout,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [DATA_W-1:0] m_axis_tuser,
   output logic              m_axis_tlast
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   seq_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_d;
   logic              inflight_q, inflight_d;
   logic              infl_last_q, infl_last_d;
   logic              busy_d, done_d;
   logic [1:0]        occ_c;
   logic              pop_c, can_issue_c, addr_last_c;

   assign pop_c       = m_axis_tvalid & m_axis_tready;
   assign addr_last_c = (rd_addr == LAST_ADDR);
   // Issue only if the buffer can still absorb the byte even if the sink stalls forever.
   assign can_issue_c = (3'(occ_c) + 3'(inflight_q)) < (3'd2 + 3'(pop_c));

   always_comb begin
      state_d     = state_q;
      addr_d      = rd_addr;
      inflight_d  = 1'b0;
      infl_last_d = infl_last_q;
      busy_d      = busy;
      done_d      = pop_c & m_axis_tlast;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               addr_d  = '0;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            if (can_issue_c) begin
               inflight_d  = 1'b1;
               infl_last_d = addr_last_c;
               if (addr_last_c) begin
`ifdef FLOATING_POINT_TLAST_TUSER_SEQ_LOOP_EN
                  addr_d = '0;
`else
                  state_d = DRAIN;
`endif
               end else begin
                  addr_d = rd_addr + ADDR_W'(1);
               end
            end
         end
         DRAIN: begin
            if (pop_c && m_axis_tlast) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rd_addr     <= '0;
         inflight_q  <= 1'b0;
         infl_last_q <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_addr     <= addr_d;
         inflight_q  <= inflight_d;
         infl_last_q <= infl_last_d;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

   floating_point_tlast_tuser_skid2 #(.DATA_W(DATA_W)) u_skid (
      .clk          (clk),
      .rst_n        (rst_n),
      .push         (inflight_q),
      .push_tuser   (rom_dout),
      .push_tlast   (infl_last_q),
      .m_axis_tready(m_axis_tready),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tuser (m_axis_tuser),
      .m_axis_tlast (m_axis_tlast),
      .occ_c        (occ_c)
   );

endmodule

// File: tb/tb_floating_point_tlast_tuser_seq.sv
// Directed bench for the sideband ROM sequencer with a registered ROM model (0x90, 0x81 .. 0x09).
module tb_floating_point_tlast_tuser_seq;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              busy, done;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rom_dout;
   logic              m_axis_tvalid;
   logic              m_axis_tready = 1'b0;
   logic [DATA_W-1:0] m_axis_tuser;
   logic              m_axis_tlast;

   logic [DATA_W-1:0] rom [16];
   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       start;
      logic       tready;
      logic       tvalid;
      logic [7:0] tuser;
      logic       tlast;
      logic       done;
      logic       busy;
      logic [3:0] rd_addr;
   } vec_t;

   vec_t vecs [15];

   always #5 clk = ~clk;

   always @(posedge clk) rom_dout <= rom[rd_addr];

   floating_point_tlast_tuser_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .rd_addr      (rd_addr),
      .rom_dout     (rom_dout),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tuser (m_axis_tuser),
      .m_axis_tlast (m_axis_tlast)
   );

   function automatic logic [7:0] exp_byte(input int k);
      logic [7:0] b;
      b = 8'h90 - 8'(15 * k);
      return b;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // One run: optional start, optional random tready, optional start pokes, optional initial stall.
   task automatic stream_run(input string tag, input bit do_start, input bit rnd,
                             input bit poke, input int stall);
      int beats = 0;
      int dones = 0;
      int cyc = 0;
      int stall_left;
      bit seen_valid = 1'b0;
      bit prev_hold = 1'b0;
      bit stalling;
      logic [7:0] prev_tuser = 8'h00;
      logic prev_tlast = 1'b0;
      stall_left = stall;
      while (dones == 0 && cyc < 400) begin
         @(posedge clk); #1;
         start = (cyc == 0 && do_start) || (poke && (beats == 3 || beats == 7));
         stalling = 1'b0;
         if (stall_left > 0) begin
            m_axis_tready = 1'b0;
            if (seen_valid) begin
               stall_left--;
               stalling = 1'b1;
            end
         end else begin
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         @(negedge clk);
         if (prev_hold)
            check($sformatf("%s hold beat %0d", tag, beats),
                  32'({m_axis_tvalid, m_axis_tuser, m_axis_tlast}),
                  32'({1'b1, prev_tuser, prev_tlast}));
         if (stalling)
            check($sformatf("%s stall rd_addr=%0d tuser", tag, rd_addr),
                  32'({rd_addr <= 4'd2, m_axis_tvalid, m_axis_tuser}),
                  32'({1'b1, 1'b1, 8'h90}));
         if (m_axis_tvalid) seen_valid = 1'b1;
         if (m_axis_tvalid && m_axis_tready) begin
            check($sformatf("%s beat %0d", tag, beats),
                  32'({m_axis_tuser, m_axis_tlast}),
                  32'({exp_byte(beats), beats == int'(DEPTH) - 1}));
            beats++;
         end
         if (done) dones++;
         prev_hold  = m_axis_tvalid && !m_axis_tready;
         prev_tuser = m_axis_tuser;
         prev_tlast = m_axis_tlast;
         cyc++;
      end
      check({tag, " beat count"}, 32'(beats), 32'(DEPTH));
      check({tag, " done count"}, 32'(dones), 32'd1);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         m_axis_tready = 1'b1;
         @(negedge clk);
         check($sformatf("%s idle %0d", tag, i), 32'({m_axis_tvalid, done, busy}), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) rom[i] = (i < int'(DEPTH)) ? exp_byte(i) : 8'hEE;

      // {start, tready, tvalid, tuser, tlast, done, busy, rd_addr} per cycle, start in cycle 0
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h90, 1'b0, 1'b0, 1'b1, 4'd2};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 4'd3};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h72, 1'b0, 1'b0, 1'b1, 4'd4};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h63, 1'b0, 1'b0, 1'b1, 4'd5};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'h54, 1'b0, 1'b0, 1'b1, 4'd6};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h45, 1'b0, 1'b0, 1'b1, 4'd7};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h36, 1'b0, 1'b0, 1'b1, 4'd8};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h27, 1'b0, 1'b0, 1'b1, 4'd9};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 8'h18, 1'b0, 1'b0, 1'b1, 4'd9};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 8'h09, 1'b1, 1'b0, 1'b1, 4'd9};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd9};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0};

      #2;
      check("reset outputs",
            32'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, done, busy, rd_addr}), 32'd0);
      #10 rst_n = 1'b1;

`ifdef FLOATING_POINT_TLAST_TUSER_SEQ_LOOP_EN
      begin
         bit prev_last = 1'b0;
         int k;
         @(posedge clk); #1;
         start = 1'b1;
         m_axis_tready = 1'b1;
         for (int c = 1; c < 35; c++) begin
            @(posedge clk); #1;
            start = (c == 15);
            @(negedge clk);
            if (c >= 3) begin
               k = (c - 3) % int'(DEPTH);
               check($sformatf("loop beat c%0d", c),
                     32'({m_axis_tvalid, m_axis_tuser, m_axis_tlast}),
                     32'({1'b1, exp_byte(k), k == int'(DEPTH) - 1}));
            end else begin
               check($sformatf("loop pre c%0d", c), 32'(m_axis_tvalid), 32'd0);
            end
            check($sformatf("loop done/busy c%0d", c), 32'({done, busy}), 32'({prev_last, 1'b1}));
            prev_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;
         end
      end
`else
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         start = vecs[i].start;
         m_axis_tready = vecs[i].tready;
         @(negedge clk);
         check($sformatf("vec %0d", i),
               32'({m_axis_tvalid, m_axis_tvalid ? m_axis_tuser : 8'h00,
                    m_axis_tvalid & m_axis_tlast, done, busy, rd_addr}),
               32'({vecs[i].tvalid, vecs[i].tvalid ? vecs[i].tuser : 8'h00,
                    vecs[i].tvalid & vecs[i].tlast, vecs[i].done, vecs[i].busy, vecs[i].rd_addr}));
      end
      stream_run("restart in done cycle", 1'b0, 1'b0, 1'b0, 0);

      for (int r = 0; r < 3; r++)
         stream_run($sformatf("random run %0d", r), 1'b1, 1'b1, 1'b0, 0);

      stream_run("stall 20", 1'b1, 1'b0, 1'b0, 20);

      stream_run("start poke", 1'b1, 1'b0, 1'b1, 0);

      stream_run("depth check", 1'b1, 1'b1, 1'b0, 0);

      // Abort with reset at beat 5, then a clean run from address 0.
      begin
         int cyc = 0;
         bit hit = 1'b0;
         @(posedge clk); #1;
         start = 1'b1;
         m_axis_tready = 1'b1;
         while (!hit && cyc < 50) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tuser == exp_byte(5)) hit = 1'b1;
            cyc++;
         end
         check("reached beat 5", 32'(hit), 32'd1);
         #1 rst_n = 1'b0;
         #1;
         check("async reset outputs",
               32'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, done, busy, rd_addr}), 32'd0);
         @(posedge clk); #2;
         rst_n = 1'b1;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("after abort %0d", i),
                  32'({m_axis_tvalid, m_axis_tlast, done, busy}), 32'd0);
         end
      end
      stream_run("after reset", 1'b1, 1'b0, 1'b0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
